// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: aligner FSM encoding, RVC decode helpers and
// the canonical NOP used by the IF stage.
package fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned WADDR_W = 30;

    localparam logic [1:0]      RVC_MASK = 2'b11;
    localparam logic [XLEN-1:0] NOP      = 32'h00000013;

    typedef enum logic {
        FA_IDLE = 1'b0,
        FA_BUSY = 1'b1
    } fa_state_t;

    // One fetched word in instruction order, split into its two halfwords
    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] lo;
    } fetch_word_t;

    // ICACHE returns little-endian bytes; the aligner works on swapped words
    function automatic logic [XLEN-1:0] byte_swap(input logic [XLEN-1:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic is_rvc(input logic [15:0] half);
        return (half[1:0] & RVC_MASK) != RVC_MASK;
    endfunction

endpackage

// File: rtl/fetch_word_buffer.sv
// Single-entry word buffer for the fetch aligner: tag/data/valid registers,
// two tag compare ports and one write port.
module fetch_word_buffer
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [WADDR_W-1:0] wr_tag,
    input  logic [XLEN-1:0]    wr_data,
    input  logic [WADDR_W-1:0] tag_a,
    input  logic [WADDR_W-1:0] tag_b,
    output logic               hit_a,
    output logic               hit_b,
    output logic [XLEN-1:0]    data
);

    logic               valid;
    logic [WADDR_W-1:0] tag;

    // Newest completed word always replaces the entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            tag   <= wr_tag;
            data  <= wr_data;
        end
    end

    assign hit_a = valid && (tag == tag_a);
    assign hit_b = valid && (tag == tag_b);

endmodule

// File: rtl/fetch_aligner.sv
// Instruction fetch aligner: turns the IF byte PC into ICACHE word requests and
// assembles whole 16/32-bit instructions from the buffer and the cache bypass.
module fetch_aligner
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [XLEN-1:0]    pc,
    output logic               ready,
    output logic               compressed,
    output logic [XLEN-1:0]    inst,
    input  logic               ICACHE_stall,
    output logic               ICACHE_ren,
    output logic               ICACHE_wen,
    output logic [WADDR_W-1:0] ICACHE_addr,
    input  logic [XLEN-1:0]    ICACHE_rdata,
    output logic [XLEN-1:0]    ICACHE_wdata
);

    fa_state_t          state;
    logic [WADDR_W-1:0] req_addr;

    logic [WADDR_W-1:0] word_addr;
    logic [WADDR_W-1:0] next_addr;
    logic               half_sel;
    logic               unused_pc_lsb;

    logic               hit_w;
    logic               hit_w1;
    fetch_word_t        buf_word;
    fetch_word_t        rd_word;

    logic               want_req;
    logic [WADDR_W-1:0] want_addr;
    logic               req_en;
    logic               req_done;
    logic [WADDR_W-1:0] req_cur;

    logic               avail_w;
    logic               avail_w1;
    fetch_word_t        src_w;
    fetch_word_t        src_w1;
    logic [15:0]        half;
    logic               rvc;
    logic               ready_c;

    assign word_addr     = pc[XLEN-1:2];
    assign next_addr     = word_addr + WADDR_W'(1);
    assign half_sel      = pc[1];
    assign unused_pc_lsb = pc[0];
    assign rd_word       = byte_swap(ICACHE_rdata);

    fetch_word_buffer u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (req_done),
        .wr_tag  (req_cur),
        .wr_data (rd_word),
        .tag_a   (word_addr),
        .tag_b   (next_addr),
        .hit_a   (hit_w),
        .hit_b   (hit_w1),
        .data    (buf_word)
    );

    // Request selection: missing W first, then W+1 for a straddling 32-bit op
    always_comb begin
        want_req  = 1'b0;
        want_addr = word_addr;
        if (!hit_w) begin
            want_req = 1'b1;
        end else if (half_sel && !is_rvc(buf_word.hi) && !hit_w1) begin
            want_req  = 1'b1;
            want_addr = next_addr;
        end
        req_en   = rst_n && ((state == FA_BUSY) || want_req);
        req_cur  = (state == FA_BUSY) ? req_addr : want_addr;
        req_done = req_en && !ICACHE_stall;
    end

    // Assembly: each needed word comes from the buffer or the completing request
    always_comb begin
        avail_w  = hit_w  || (req_done && (req_cur == word_addr));
        avail_w1 = hit_w1 || (req_done && (req_cur == next_addr));
        src_w    = hit_w  ? buf_word : rd_word;
        src_w1   = hit_w1 ? buf_word : rd_word;
        half     = half_sel ? src_w.hi : src_w.lo;
        rvc      = is_rvc(half);
        ready_c  = rst_n && avail_w && (rvc || !half_sel || avail_w1);

        inst       = '0;
        compressed = 1'b0;
        if (ready_c) begin
            compressed = rvc;
            if (rvc) begin
                inst = {16'h0000, half};
            end else if (half_sel) begin
                inst = {src_w1.lo, half};
            end else begin
                inst = src_w;
            end
        end
    end

    // Request FSM: a stalled request is pinned to req_addr until it completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FA_IDLE;
            req_addr <= '0;
        end else begin
            case (state)
                FA_IDLE: begin
                    if (req_en && ICACHE_stall) begin
                        state    <= FA_BUSY;
                        req_addr <= want_addr;
                    end
                end
                FA_BUSY: begin
                    if (!ICACHE_stall) begin
                        state <= FA_IDLE;
                    end
                end
                default: state <= FA_IDLE;
            endcase
        end
    end

    assign ready        = ready_c;
    assign ICACHE_ren   = req_en;
    assign ICACHE_addr  = req_en ? req_cur : '0;
    assign ICACHE_wen   = 1'b0;
    assign ICACHE_wdata = '0;

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner: directed scenarios then randomized
// PC/stall traffic against a word-availability reference model.
module tb_fetch_aligner;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        ready;
    logic        compressed;
    logic [31:0] inst;
    logic        ICACHE_stall;
    logic        ICACHE_ren;
    logic        ICACHE_wen;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_rdata;
    logic [31:0] ICACHE_wdata;

    int errors = 0;
    int checks = 0;

    // Cache contents in instruction (swapped) order; constant between resets
    logic [31:0] mem [logic [29:0]];

    // Reference state: one buffered word and an optional pending request
    logic        m_valid = 1'b0;
    logic [29:0] m_tag   = '0;
    logic        m_busy  = 1'b0;
    logic [29:0] m_req   = '0;

    logic        last_ren;
    logic [29:0] last_addr;
    logic        last_ready;
    logic        last_cmp;
    logic [31:0] last_inst;

    always #5 clk = ~clk;

    fetch_aligner dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .ready        (ready),
        .compressed   (compressed),
        .inst         (inst),
        .ICACHE_stall (ICACHE_stall),
        .ICACHE_ren   (ICACHE_ren),
        .ICACHE_wen   (ICACHE_wen),
        .ICACHE_addr  (ICACHE_addr),
        .ICACHE_rdata (ICACHE_rdata),
        .ICACHE_wdata (ICACHE_wdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
        if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
        if ($urandom_range(0, 9) == 0) w = NOP;
        return w;
    endfunction

    function automatic logic [31:0] word_at(input logic [29:0] x);
        if (!mem.exists(x)) mem[x] = rand_word();
        return mem[x];
    endfunction

    function automatic logic [31:0] to_le(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // One clock: drive inputs, act as the cache, compare against the model
    task automatic step(input logic [31:0] p, input logic st, input logic rn);
        logic [29:0] w;
        logic [29:0] w1;
        logic        h;
        logic        hw;
        logic        hw1;
        logic        e_ren;
        logic [29:0] e_addr;
        logic        e_done;
        logic        av_w;
        logic        av_w1;
        logic [31:0] d_w;
        logic [31:0] d_w1;
        logic [15:0] half;
        logic        is32;
        logic        e_rdy;
        logic [31:0] e_inst;
        @(negedge clk);
        pc           = p;
        ICACHE_stall = st;
        rst_n        = rn;
        w   = p[31:2];
        w1  = w + 30'd1;
        h   = p[1];
        hw  = m_valid && (m_tag == w);
        hw1 = m_valid && (m_tag == w1);
        d_w  = word_at(w);
        d_w1 = word_at(w1);
        e_ren  = 1'b0;
        e_addr = '0;
        if (rn) begin
            if (m_busy) begin
                e_ren = 1'b1; e_addr = m_req;
            end else if (!hw) begin
                e_ren = 1'b1; e_addr = w;
            end else if (h && d_w[17:16] == 2'b11 && !hw1) begin
                e_ren = 1'b1; e_addr = w1;
            end
        end
        #1;
        check_eq("ren", 32'(ICACHE_ren), 32'(e_ren));
        check_eq("addr", 32'(ICACHE_addr), 32'(e_addr));
        check_eq("wen", 32'(ICACHE_wen), 32'd0);
        check_eq("wdata", ICACHE_wdata, 32'd0);
        e_done = e_ren && !st;
        ICACHE_rdata = e_done ? to_le(word_at(e_addr)) : $urandom;
        #1;
        av_w  = hw  || (e_done && e_addr == w);
        av_w1 = hw1 || (e_done && e_addr == w1);
        half  = h ? d_w[31:16] : d_w[15:0];
        is32  = (half[1:0] == 2'b11);
        e_rdy = rn && av_w && (!(h && is32) || av_w1);
        e_inst = '0;
        if (e_rdy) e_inst = !is32 ? {16'h0, half} : (h ? {d_w1[15:0], half} : d_w);
        check_eq("ready", 32'(ready), 32'(e_rdy));
        check_eq("compressed", 32'(compressed), 32'(e_rdy && !is32));
        check_eq("inst", inst, e_inst);
        last_ren   = ICACHE_ren;
        last_addr  = ICACHE_addr;
        last_ready = ready;
        last_cmp   = compressed;
        last_inst  = inst;
        if (!rn) begin
            m_valid = 1'b0; m_tag = '0; m_busy = 1'b0; m_req = '0;
        end else begin
            if (e_done) begin
                m_valid = 1'b1; m_tag = e_addr;
            end
            m_busy = e_ren && st;
            if (e_ren) m_req = e_addr;
        end
    endtask

    task automatic do_reset();
        step(32'h0, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0);
        mem.delete();
    endtask

    initial begin
        logic [31:0] cur;
        logic        st;
        rst_n = 1'b0; pc = '0; ICACHE_stall = 1'b0; ICACHE_rdata = '0;

        do_reset();
        check_eq("rst_ready", 32'(last_ready), 32'd0);
        check_eq("rst_ren", 32'(last_ren), 32'd0);

        // Same-cycle cache hit, then RVC pair with the second served from buffer
        mem[30'h0] = 32'h00000513;
        mem[30'h1] = 32'h45014501;
        step(32'h0, 1'b0, 1'b1);
        check_eq("hit_ready", 32'(last_ready), 32'd1);
        check_eq("hit_inst", last_inst, 32'h00000513);
        step(32'h4, 1'b0, 1'b1);
        check_eq("rvc_inst", last_inst, 32'h00004501);
        check_eq("rvc_cmp", 32'(last_cmp), 32'd1);
        step(32'h6, 1'b0, 1'b1);
        check_eq("rvc_buf_ren", 32'(last_ren), 32'd0);
        check_eq("rvc_buf_ready", 32'(last_ready), 32'd1);

        // Straddling 32-bit instruction with an empty buffer
        do_reset();
        mem[30'h0] = 32'h05134501;
        mem[30'h1] = 32'h00000000;
        step(32'h2, 1'b0, 1'b1);
        check_eq("strad_addr0", 32'(last_addr), 32'd0);
        check_eq("strad_ready0", 32'(last_ready), 32'd0);
        step(32'h2, 1'b0, 1'b1);
        check_eq("strad_addr1", 32'(last_addr), 32'd1);
        check_eq("strad_inst", last_inst, 32'h00000513);
        check_eq("strad_cmp", 32'(last_cmp), 32'd0);

        // Five-cycle miss
        do_reset();
        mem[30'h2] = NOP;
        for (int i = 0; i < 5; i++) begin
            step(32'h8, 1'b1, 1'b1);
            check_eq("miss_addr", 32'(last_addr), 32'd2);
            check_eq("miss_ready", 32'(last_ready), 32'd0);
        end
        step(32'h8, 1'b0, 1'b1);
        check_eq("miss_done_inst", last_inst, NOP);

        // Redirect while busy
        do_reset();
        mem[30'h20] = 32'h00004501;
        step(32'h10, 1'b1, 1'b1);
        step(32'h80, 1'b1, 1'b1);
        check_eq("redir_addr", 32'(last_addr), 32'd4);
        step(32'h80, 1'b0, 1'b1);
        check_eq("redir_old_ready", 32'(last_ready), 32'd0);
        step(32'h80, 1'b0, 1'b1);
        check_eq("redir_new_addr", 32'(last_addr), 32'h20);
        check_eq("redir_new_inst", last_inst, 32'h00004501);

        // Reset during busy clears the buffer
        do_reset();
        step(32'h100, 1'b0, 1'b1);
        step(32'h104, 1'b1, 1'b1);
        step(32'h104, 1'b1, 1'b0);
        check_eq("rbusy_ren", 32'(last_ren), 32'd0);
        step(32'h100, 1'b0, 1'b1);
        check_eq("rbusy_rereq", 32'(last_addr), 32'h40);

        // Word address wrap for a straddle at the top of memory
        do_reset();
        mem[30'h3FFFFFFF] = 32'h05130000;
        mem[30'h0]        = 32'h00001234;
        step(32'hFFFFFFFE, 1'b0, 1'b1);
        check_eq("wrap_addr0", 32'(last_addr), 32'h3FFFFFFF);
        step(32'hFFFFFFFE, 1'b0, 1'b1);
        check_eq("wrap_addr1", 32'(last_addr), 32'd0);
        check_eq("wrap_inst", last_inst, 32'h12340513);

        // Randomized traffic
        do_reset();
        cur = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            st = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 99) == 0) begin
                step(cur, st, 1'b0);
                continue;
            end
            step(cur, st, 1'b1);
            if ((last_ready && $urandom_range(0, 99) < 85) ||
                (!last_ready && $urandom_range(0, 99) < 95)) begin
                if (last_ready) cur = cur + (last_cmp ? 32'd2 : 32'd4);
            end else begin
                case ($urandom_range(0, 3))
                    0: cur = 32'($urandom_range(0, 255)) << 1;
                    1: cur = 32'hFFFFFF00 | (32'($urandom_range(0, 127)) << 1);
                    2: cur = 32'hFFFFFFFE;
                    default: cur = cur + (32'($urandom_range(0, 15)) << 1);
                endcase
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
